regfile_hilo_sb: RTL and testbench

REGFILE_HILO_SB -- requirements
Module: regfile_hilo_sb

---
 rtl/regfile_hilo_sb_pkg.sv | 14 +
 rtl/regfile_sb_score.sv | 81 ++++++++
 rtl/regfile_hilo_sb.sv | 90 +++++++++
 tb/tb_regfile_hilo_sb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_hilo_sb_pkg.sv
// Shared defaults and packed-port width helpers for the GPR/HI/LO register file
// and its producer scoreboard.
package regfile_hilo_sb_pkg;

  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned AW_DEF  = 5;
  localparam int unsigned NRD_DEF = 2;

  // Width of a bus carrying n fields of w bits each (packed read ports).
  function automatic int unsigned pack_w(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

endpackage

// File: rtl/regfile_sb_score.sv
// Producer scoreboard: one pending bit per GPR plus one for HI/LO, set-wins
// priority against writeback, and a registered count of pending GPRs.
module regfile_sb_score
  import regfile_hilo_sb_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned NRD = NRD_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [pack_w(NRD, AW)-1:0]  raddr,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic                        hilo_wr,
  input  logic                        issue_v,
  input  logic [AW-1:0]               issue_rd,
  input  logic                        issue_hilo,
  output logic [NRD-1:0]              rd_busy,
  output logic                        hilo_busy,
  output logic [AW:0]                 pend_cnt
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = AW + 1;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic            hilo_pend;
  logic            hilo_nxt;
  logic            wr_ok;
  logic            iss_ok;
  logic            inc;
  logic            dec;

  assign wr_ok  = we && (waddr != '0);
  assign iss_ok = issue_v && (issue_rd != '0);

  // Clear first so a same-cycle issue (the newer producer) overrides it.
  always_comb begin
    pend_nxt = pend;
    hilo_nxt = hilo_pend;
    inc      = 1'b0;
    dec      = 1'b0;
    if (wr_ok) begin
      pend_nxt[waddr] = 1'b0;
    end
    if (iss_ok) begin
      pend_nxt[issue_rd] = 1'b1;
    end
    if (hilo_wr) begin
      hilo_nxt = 1'b0;
    end
    if (issue_v && issue_hilo) begin
      hilo_nxt = 1'b1;
    end
    inc = iss_ok && !pend[issue_rd];
    dec = wr_ok && pend[waddr] && !(iss_ok && (issue_rd == waddr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      hilo_pend <= 1'b0;
      pend_cnt  <= '0;
    end else begin
      pend      <= pend_nxt;
      hilo_pend <= hilo_nxt;
      pend_cnt  <= pend_cnt + CW'(inc) - CW'(dec);
    end
  end

  // A writeback landing this cycle is forwarded, so it does not stall the reader.
  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [AW-1:0] ra;
    assign ra         = raddr[k*AW +: AW];
    assign rd_busy[k] = (ra != '0) && pend[ra] && !(we && (waddr == ra));
  end

  assign hilo_busy = hilo_pend && !hilo_wr;

endmodule

// File: rtl/regfile_hilo_sb.sv
// Multi-port GPR file with HI/LO registers, write-through bypass on every read
// port, and a producer scoreboard for hazard detection.
module regfile_hilo_sb
  import regfile_hilo_sb_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned NRD = NRD_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [pack_w(NRD, AW)-1:0]  raddr,
  output logic [pack_w(NRD, DW)-1:0]  rdata,
  output logic [NRD-1:0]              rd_busy,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [DW-1:0]               wdata,
  input  logic                        hi_we,
  input  logic                        lo_we,
  input  logic [DW-1:0]               hi_i,
  input  logic [DW-1:0]               lo_i,
  output logic [DW-1:0]               hi_o,
  output logic [DW-1:0]               lo_o,
  output logic                        hilo_busy,
  input  logic                        issue_v,
  input  logic [AW-1:0]               issue_rd,
  input  logic                        issue_hilo,
  output logic [AW:0]                 pend_cnt
);

  localparam int unsigned NREG = 2 ** AW;

  logic [DW-1:0] gpr [NREG];
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;
  logic          wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr[i] <= '0;
      end
    end else if (wr_ok) begin
      gpr[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_i;
      if (lo_we) lo_q <= lo_i;
    end
  end

  // Address 0 is hard-wired zero; a matching write is forwarded the same cycle.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[k*AW +: AW];
    assign rdata[k*DW +: DW] = (ra == '0)                 ? '0    :
                               (wr_ok && (ra == waddr))   ? wdata :
                                                            gpr[ra];
  end

  assign hi_o = hi_we ? hi_i : hi_q;
  assign lo_o = lo_we ? lo_i : lo_q;

  regfile_sb_score #(
    .AW  (AW),
    .NRD (NRD)
  ) u_score (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .we         (we),
    .waddr      (waddr),
    .hilo_wr    (hi_we || lo_we),
    .issue_v    (issue_v),
    .issue_rd   (issue_rd),
    .issue_hilo (issue_hilo),
    .rd_busy    (rd_busy),
    .hilo_busy  (hilo_busy),
    .pend_cnt   (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_hilo_sb.sv
// Directed bench for regfile_hilo_sb: bypass, zero register, HI/LO, scoreboard
// set/clear priority and asynchronous reset.
module tb_regfile_hilo_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        hi_we, lo_we;
  logic [31:0] hi_i, lo_i, hi_o, lo_o;
  logic        hilo_busy;
  logic        issue_v;
  logic [4:0]  issue_rd;
  logic        issue_hilo;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int passes = 0;

  regfile_hilo_sb dut (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .rdata      (rdata),
    .rd_busy    (rd_busy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .hilo_busy  (hilo_busy),
    .issue_v    (issue_v),
    .issue_rd   (issue_rd),
    .issue_hilo (issue_hilo),
    .pend_cnt   (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_i = '0; lo_i = '0;
    issue_v = 1'b0; issue_rd = '0; issue_hilo = 1'b0;
  endtask

  task automatic set_ra(input int k, input logic [4:0] a);
    raddr[k*5 +: 5] = a;
  endtask

  initial begin
    raddr = '0;
    idle();
    // Activity during reset must be discarded.
    rst = 1'b1;
    we = 1'b1; waddr = 5'd3; wdata = 32'd55;
    issue_v = 1'b1; issue_rd = 5'd4; issue_hilo = 1'b1;
    hi_we = 1'b1; hi_i = 32'd7;
    #1;
    chk("rst_cnt", 64'(pend_cnt), 64'd0);
    tick();
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_cnt", 64'(pend_cnt), 64'd0);
    chk("post_rst_hilo_busy", 64'(hilo_busy), 64'd0);
    chk("post_rst_hi", 64'(hi_o), 64'd0);
    chk("post_rst_lo", 64'(lo_o), 64'd0);

    // All addresses read zero and not busy after reset.
    for (int a = 0; a < 32; a++) begin
      set_ra(0, 5'(a));
      set_ra(1, 5'(31 - a));
      #1;
      chk("rst_rd0", 64'(rdata[31:0]), 64'd0);
      chk("rst_rd1", 64'(rdata[63:32]), 64'd0);
      chk("rst_busy", 64'(rd_busy), 64'd0);
    end

    // Bypass on write to r5, then stored value.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    set_ra(0, 5'd5); set_ra(1, 5'd6);
    #1;
    chk("byp_r5", 64'(rdata[31:0]), 64'hDEADBEEF);
    chk("byp_r6", 64'(rdata[63:32]), 64'd0);
    tick();
    idle();
    #1;
    chk("st_r5", 64'(rdata[31:0]), 64'hDEADBEEF);

    // Writes to r0 are ignored.
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    set_ra(0, 5'd0);
    #1;
    chk("r0_byp", 64'(rdata[31:0]), 64'd0);
    tick();
    idle();
    #1;
    chk("r0_st", 64'(rdata[31:0]), 64'd0);
    chk("r0_cnt", 64'(pend_cnt), 64'd0);

    // GPR, HI and LO written together.
    we = 1'b1; waddr = 5'd3; wdata = 32'hC;
    hi_we = 1'b1; hi_i = 32'hA; lo_we = 1'b1; lo_i = 32'hB;
    set_ra(1, 5'd3);
    #1;
    chk("hi_byp", 64'(hi_o), 64'hA);
    chk("lo_byp", 64'(lo_o), 64'hB);
    tick();
    idle();
    hi_i = 32'hFF; lo_i = 32'hEE;
    #1;
    chk("hi_st", 64'(hi_o), 64'hA);
    chk("lo_st", 64'(lo_o), 64'hB);
    chk("r3_st", 64'(rdata[63:32]), 64'hC);

    // Issue r7, re-issue with writeback (set wins), then plain writeback.
    issue_v = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    set_ra(0, 5'd7); set_ra(1, 5'd0);
    #1;
    chk("iss7_cnt", 64'(pend_cnt), 64'd1);
    chk("iss7_busy", 64'(rd_busy), 64'b01);
    issue_v = 1'b1; issue_rd = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'd77;
    #1;
    chk("fwd7_busy", 64'(rd_busy), 64'b00);
    chk("fwd7_data", 64'(rdata[31:0]), 64'd77);
    tick();
    idle();
    #1;
    chk("coll7_cnt", 64'(pend_cnt), 64'd1);
    chk("coll7_busy", 64'(rd_busy), 64'b01);
    we = 1'b1; waddr = 5'd7; wdata = 32'd78;
    tick();
    idle();
    #1;
    chk("wb7_cnt", 64'(pend_cnt), 64'd0);
    chk("wb7_busy", 64'(rd_busy), 64'b00);
    chk("wb7_data", 64'(rdata[31:0]), 64'd78);

    // Issue to r0 is ignored.
    issue_v = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    #1;
    chk("iss0_cnt", 64'(pend_cnt), 64'd0);

    // Issue r10 while clearing r11: net zero change.
    issue_v = 1'b1; issue_rd = 5'd11;
    tick();
    idle();
    issue_v = 1'b1; issue_rd = 5'd10;
    we = 1'b1; waddr = 5'd11; wdata = 32'd11;
    tick();
    idle();
    set_ra(0, 5'd10); set_ra(1, 5'd11);
    #1;
    chk("swap_cnt", 64'(pend_cnt), 64'd1);
    chk("swap_busy", 64'(rd_busy), 64'b01);
    we = 1'b1; waddr = 5'd12; wdata = 32'd12;
    tick();
    idle();
    #1;
    chk("nonpend_wr_cnt", 64'(pend_cnt), 64'd1);
    we = 1'b1; waddr = 5'd10; wdata = 32'd10;
    tick();
    idle();
    #1;
    chk("wb10_cnt", 64'(pend_cnt), 64'd0);

    // HI/LO scoreboard: set, forwarded clear, collision, clear.
    issue_v = 1'b1; issue_hilo = 1'b1;
    tick();
    idle();
    #1;
    chk("hilo_set", 64'(hilo_busy), 64'd1);
    lo_we = 1'b1; lo_i = 32'h5;
    #1;
    chk("hilo_fwd", 64'(hilo_busy), 64'd0);
    issue_v = 1'b1; issue_hilo = 1'b1;
    tick();
    idle();
    #1;
    chk("hilo_coll", 64'(hilo_busy), 64'd1);
    chk("lo_wr", 64'(lo_o), 64'h5);
    hi_we = 1'b1; hi_i = 32'h6;
    tick();
    idle();
    #1;
    chk("hilo_clr", 64'(hilo_busy), 64'd0);
    chk("hi_wr", 64'(hi_o), 64'h6);

    // Reset mid-sequence with a writeback pending.
    issue_v = 1'b1; issue_rd = 5'd9; issue_hilo = 1'b1;
    tick();
    idle();
    #1;
    chk("pre_rst_cnt", 64'(pend_cnt), 64'd1);
    chk("pre_rst_hilo", 64'(hilo_busy), 64'd1);
    rst = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'd99;
    #1;
    chk("async_cnt", 64'(pend_cnt), 64'd0);
    chk("async_hilo", 64'(hilo_busy), 64'd0);
    chk("async_hi", 64'(hi_o), 64'd0);
    tick();
    idle();
    rst = 1'b0;
    set_ra(0, 5'd9); set_ra(1, 5'd5);
    #1;
    chk("rst2_r9", 64'(rdata[31:0]), 64'd0);
    chk("rst2_r5", 64'(rdata[63:32]), 64'd0);
    chk("rst2_busy", 64'(rd_busy), 64'b00);
    chk("rst2_cnt", 64'(pend_cnt), 64'd0);
    chk("rst2_hilo", 64'(hilo_busy), 64'd0);
    chk("rst2_lo", 64'(lo_o), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
